// File: rtl/seq_det_sched.sv
// Round-robin arbiter that time-shares one serial 1011 detector among
// NREQ byte requesters, serialising each granted byte and counting hits.
module seq_det_sched #(
    parameter int NREQ   = 4,
    parameter int BYTE_W = 8,
    parameter int CNT_W  = 4,
    localparam int IDW   = $clog2(NREQ),
    localparam int BCW   = $clog2(BYTE_W)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*BYTE_W-1:0] data,
    output logic [NREQ-1:0]        gnt,
    output logic                   det_din,
    output logic                   det_valid,
    output logic                   det_clr,
    input  logic                   det_hit,
    output logic                   done,
    output logic [IDW-1:0]         done_id,
    output logic [CNT_W-1:0]       hit_cnt,
    output logic                   busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_SHIFT,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDW-1:0]     r_rr_ptr;
    logic [IDW-1:0]     r_cur_id;
    logic [BYTE_W-1:0]  r_sr;
    logic [BCW-1:0]     r_bitcnt;
    logic               r_samp;
    logic [CNT_W-1:0]   r_hit_cnt;

    logic               w_any;
    logic [IDW-1:0]     w_gnt_id;
    logic [NREQ-1:0]    w_gnt;
    logic               w_take;
    logic               w_last_bit;

    // First set request at or after the round-robin pointer, with wrap.
    always_comb begin
        w_any    = 1'b0;
        w_gnt_id = '0;
        w_gnt    = '0;
        if (r_state == S_IDLE) begin
            for (int k = 0; k < NREQ; k++) begin
                if (!w_any && req[(int'(r_rr_ptr) + k) % NREQ]) begin
                    w_any    = 1'b1;
                    w_gnt_id = IDW'((int'(r_rr_ptr) + k) % NREQ);
                end
            end
        end
        if (w_any) begin
            w_gnt[w_gnt_id] = 1'b1;
        end
    end

    assign w_take     = (r_state == S_IDLE) && w_any;
    assign w_last_bit = (r_bitcnt == BCW'(BYTE_W - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (w_any) w_state_nxt = S_CLR;
            S_CLR:   w_state_nxt = S_SHIFT;
            S_SHIFT: if (w_last_bit) w_state_nxt = S_DRAIN;
            S_DRAIN: w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr  <= '0;
            r_cur_id  <= '0;
            r_sr      <= '0;
            r_bitcnt  <= '0;
            r_samp    <= 1'b0;
            r_hit_cnt <= '0;
        end else begin
            // Detector output lags its input by one cycle.
            r_samp <= (r_state == S_SHIFT);
            if (w_take) begin
                r_sr      <= data[int'(w_gnt_id) * BYTE_W +: BYTE_W];
                r_cur_id  <= w_gnt_id;
                r_rr_ptr  <= IDW'((int'(w_gnt_id) + 1) % NREQ);
                r_hit_cnt <= '0;
            end else if (r_samp && det_hit && (r_hit_cnt != '1)) begin
                r_hit_cnt <= r_hit_cnt + CNT_W'(1);
            end
            if (r_state == S_SHIFT) begin
                r_sr     <= r_sr << 1;
                r_bitcnt <= w_last_bit ? '0 : r_bitcnt + BCW'(1);
            end
        end
    end

    assign gnt       = w_gnt;
    assign det_valid = (r_state == S_SHIFT);
    assign det_din   = (r_state == S_SHIFT) && r_sr[BYTE_W-1];
    assign det_clr   = (r_state == S_CLR);
    assign done      = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign done_id   = r_cur_id;
    assign hit_cnt   = r_hit_cnt;

endmodule

// File: tb/tb_seq_det_sched.sv
// Bench for seq_det_sched: behavioural 1011 detector, vector table,
// grant/done scoreboard queues and hand-written corner sequences.
module tb_seq_det_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  gnt;
    logic        det_din;
    logic        det_valid;
    logic        det_clr;
    logic        det_hit;
    logic        done;
    logic [1:0]  done_id;
    logic [3:0]  hit_cnt;
    logic        busy;

    seq_det_sched #(.NREQ(4), .BYTE_W(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .req(req), .data(data), .gnt(gnt),
        .det_din(det_din), .det_valid(det_valid), .det_clr(det_clr),
        .det_hit(det_hit), .done(done), .done_id(done_id),
        .hit_cnt(hit_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Overlapping Mealy 1011 detector, hit registered, cleared by det_clr.
    logic [1:0] m_st;
    logic       m_hit;
    logic       force_hit = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_st  <= 2'd0;
            m_hit <= 1'b0;
        end else if (det_clr) begin
            m_st  <= 2'd0;
            m_hit <= 1'b0;
        end else if (det_valid) begin
            m_hit <= (m_st == 2'd3) && det_din;
            case (m_st)
                2'd0: m_st <= det_din ? 2'd1 : 2'd0;
                2'd1: m_st <= det_din ? 2'd1 : 2'd2;
                2'd2: m_st <= det_din ? 2'd3 : 2'd0;
                default: m_st <= det_din ? 2'd1 : 2'd2;
            endcase
        end else begin
            m_hit <= 1'b0;
        end
    end

    assign det_hit = (force_hit && (det_clr || !busy)) ? 1'b1 : m_hit;

    typedef struct {
        int         id;
        int         cnt;
        logic [7:0] byte_v;
    } exp_t;

    int   gnt_q[$];
    exp_t done_q[$];

    int         cyc = 0;
    int         g_cyc = 0;
    int         g_count = 0;
    int         d_count = 0;
    int         clr_count = 0;
    int         last_done = -1;
    bit         spacing_on = 1'b0;
    bit         prev_gnt = 1'b0;
    logic [7:0] cap = '0;
    int         ncap = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (busy) chk("gnt_while_busy", int'(gnt), 0);
            if (gnt != 0) begin
                chk("gnt_onehot", int'($onehot(gnt)), 1);
                if (gnt_q.size() == 0) begin
                    chk("unexpected_gnt", int'(gnt), 0);
                end else begin
                    int e;
                    e = gnt_q.pop_front();
                    chk("gnt", int'(gnt), 1 << e);
                end
                g_cyc = cyc;
                g_count++;
            end
            if (det_clr) begin
                chk("clr_after_gnt", int'(prev_gnt), 1);
                clr_count++;
                cap  = '0;
                ncap = 0;
            end
            if (det_valid) begin
                cap = {cap[6:0], det_din};
                ncap++;
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = done_q.pop_front();
                    chk("done_id", int'(done_id), e.id);
                    chk("hit_cnt", int'(hit_cnt), e.cnt);
                    chk("serial_byte", int'(cap), int'(e.byte_v));
                    chk("serial_bits", ncap, 8);
                    chk("latency", cyc - g_cyc, 11);
                    if (spacing_on && last_done >= 0)
                        chk("done_spacing", cyc - last_done, 12);
                    last_done = cyc;
                end
                d_count++;
            end
            prev_gnt = (gnt != 0);
        end
    end

    task automatic wait_g(input int target);
        for (int i = 0; i < 200 && g_count < target; i++) begin
            @(negedge clk);
            #1;
        end
        if (g_count < target) chk("timeout_gnt", g_count, target);
    endtask

    task automatic wait_d(input int target);
        for (int i = 0; i < 200 && d_count < target; i++) begin
            @(negedge clk);
            #1;
        end
        if (d_count < target) chk("timeout_done", d_count, target);
    endtask

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        int          id;
        int          cnt;
    } vec_t;

    task automatic run_vec(input vec_t v);
        exp_t e;
        int   g0;
        int   d0;
        e.id     = v.id;
        e.cnt    = v.cnt;
        e.byte_v = 8'(v.data >> (8 * v.id));
        gnt_q.push_back(v.id);
        done_q.push_back(e);
        g0 = g_count;
        d0 = d_count;
        @(posedge clk);
        #1;
        req  = v.req;
        data = v.data;
        wait_g(g0 + 1);
        @(posedge clk);
        #1;
        req = '0;
        wait_d(d0 + 1);
    endtask

    task automatic push_exp(input int id, input int cnt, input logic [7:0] b);
        exp_t e;
        e.id     = id;
        e.cnt    = cnt;
        e.byte_v = b;
        gnt_q.push_back(id);
        done_q.push_back(e);
    endtask

    initial begin
        repeat (5000) @(posedge clk);
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[7];
        int   g0;
        int   d0;
        int   c0;
        vec_t v;

        tbl[0] = '{4'b0001, 32'h000000B0, 0, 1};
        tbl[1] = '{4'b0100, 32'h00B60000, 2, 2};
        tbl[2] = '{4'b0100, 32'h00000000, 2, 0};
        tbl[3] = '{4'b0100, 32'h00FF0000, 2, 0};
        tbl[4] = '{4'b0011, 32'h0000F00B, 0, 1};
        tbl[5] = '{4'b0011, 32'h00002D00, 1, 1};
        tbl[6] = '{4'b1001, 32'hDB000000, 3, 2};

        rst  = 1'b1;
        req  = '0;
        data = '0;
        repeat (2) @(negedge clk);
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_det_valid", int'(det_valid), 0);
        chk("rst_det_clr", int'(det_clr), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_hit_cnt", int'(hit_cnt), 0);
        chk("rst_busy", int'(busy), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 7; i++) run_vec(tbl[i]);

        // All four requesting at once, held: strict rotation from 0.
        g0 = g_count;
        d0 = d_count;
        push_exp(0, 1, 8'hB0);
        push_exp(1, 2, 8'hB6);
        push_exp(2, 0, 8'h00);
        push_exp(3, 1, 8'h0B);
        push_exp(0, 1, 8'hB0);
        spacing_on = 1'b1;
        last_done  = -1;
        @(posedge clk);
        #1;
        req  = 4'b1111;
        data = 32'h0B00B6B0;
        wait_g(g0 + 5);
        @(posedge clk);
        #1;
        req = '0;
        wait_d(d0 + 5);
        spacing_on = 1'b0;

        // Spurious det_hit outside the sample window must be ignored.
        force_hit = 1'b1;
        v = '{4'b0001, 32'h00000000, 0, 0};
        run_vec(v);
        force_hit = 1'b0;

        // Same requester back to back, byte swapped after its grant.
        g0 = g_count;
        d0 = d_count;
        c0 = clr_count;
        push_exp(0, 1, 8'h0B);
        push_exp(0, 1, 8'hB0);
        spacing_on = 1'b1;
        last_done  = -1;
        @(posedge clk);
        #1;
        req  = 4'b0001;
        data = 32'h0000000B;
        wait_g(g0 + 1);
        @(posedge clk);
        #1;
        data = 32'h000000B0;
        wait_g(g0 + 2);
        @(posedge clk);
        #1;
        req = '0;
        wait_d(d0 + 2);
        spacing_on = 1'b0;
        chk("clr_pulses", clr_count - c0, 2);

        // Reset in the middle of SHIFT bit 4.
        g0 = g_count;
        d0 = d_count;
        gnt_q.push_back(2);
        @(posedge clk);
        #1;
        req  = 4'b0100;
        data = 32'h00B60000;
        wait_g(g0 + 1);
        @(posedge clk);
        #1;
        req = '0;
        repeat (5) @(posedge clk);
        #1;
        chk("pre_rst_valid", int'(det_valid), 1);
        chk("pre_rst_done_id", int'(done_id), 2);
        rst = 1'b1;
        #1;
        chk("mid_rst_gnt", int'(gnt), 0);
        chk("mid_rst_din", int'(det_din), 0);
        chk("mid_rst_valid", int'(det_valid), 0);
        chk("mid_rst_clr", int'(det_clr), 0);
        chk("mid_rst_done", int'(done), 0);
        chk("mid_rst_done_id", int'(done_id), 0);
        chk("mid_rst_hit_cnt", int'(hit_cnt), 0);
        chk("mid_rst_busy", int'(busy), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("no_done_on_abort", d_count - d0, 0);

        // Pointer back at 0: of {1,3}, requester 1 must win.
        v = '{4'b1010, 32'h0000B000, 1, 1};
        run_vec(v);

        repeat (3) @(posedge clk);
        chk("gnt_q_empty", gnt_q.size(), 0);
        chk("done_q_empty", done_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/seq_det_sched.md
Name: seq_det_sched

Overview:
Round-robin scheduler that shares one serial 1011 overlapping Mealy sequence detector among NREQ byte-stream requesters.
- Grants one requester at a time and captures its byte.
- Clears the detector, then serializes the byte MSB-first onto the detector's din/valid inputs.
- Counts detector hits for that byte and reports the count with the requester ID.
- Sits between the requester ports and the detector instance; no detector state carries over between bytes.

Parameters:
NREQ, 4, number of requesters (2..8)
BYTE_W, 8, bits per transaction
CNT_W, 4, hit counter width (saturating)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
req  in  NREQ  per-requester request, level; held until granted
data  in  NREQ*BYTE_W  per-requester byte; slice i = data[i*BYTE_W +: BYTE_W]
gnt  out  NREQ  one-hot grant, combinational, high for one cycle in IDLE
det_din  out  1  serial bit to detector din
det_valid  out  1  detector valid
det_clr  out  1  one-cycle synchronous clear; integration ORs it into the detector reset
det_hit  in  1  detector seq_det (registered: reflects the bit presented in the previous cycle)
done  out  1  one-cycle pulse: result valid
done_id  out  $clog2(NREQ)  requester index of the completed transaction
hit_cnt  out  CNT_W  hits counted for that transaction
busy  out  1  high in every state except IDLE

Behaviour:
- Reset: state=IDLE, rr_ptr=0. gnt, det_din, det_valid, det_clr, done, done_id and hit_cnt are all 0; shift register, bit counter and sample flag are 0.
- States: IDLE, CLR, SHIFT, DRAIN, DONE.
- IDLE:
  - If any req is set, gnt[i]=1 for the first set req at or after rr_ptr, searching upward with wrap.
  - Same edge: capture data slice i into the shift register, cur_id=i, rr_ptr=(i+1) mod NREQ, clear hit_cnt, go to CLR.
  - If no req is set, stay in IDLE with gnt=0.
- CLR: det_clr=1 for one cycle, det_valid=0; go to SHIFT.
- SHIFT: lasts BYTE_W cycles.
  - det_valid=1 and det_din = current shift-register MSB; shift left each cycle.
  - Bit counter runs 0..BYTE_W-1. After the last bit, go to DRAIN.
- DRAIN: one cycle, det_valid=0; go to DONE.
- Hit sampling:
  - samp <= det_valid, registered.
  - In any cycle where samp=1 and det_hit=1, hit_cnt increments, saturating at 2^CNT_W-1.
  - This covers SHIFT cycles 2..BYTE_W plus DRAIN, i.e. exactly BYTE_W samples.
  - det_hit is ignored whenever samp=0.
- DONE: done=1 for one cycle; done_id=cur_id and hit_cnt hold until the next grant. Go to IDLE.
- Latency:
  - Grant edge to done pulse: 1 CLR + BYTE_W SHIFT + 1 DRAIN = BYTE_W+2 cycles, so done is high in cycle BYTE_W+3 after the grant cycle.
  - Back-to-back period: BYTE_W+4 cycles.
- Requester rules:
  - A requester must deassert req (or present a new byte) after the edge on which its gnt is high.
  - A req asserted while busy waits; there is no preemption.
- Requests arriving in the same cycle: the round-robin order decides; the lowest index at or after rr_ptr wins.
- Cross-byte matches: impossible, because det_clr precedes every byte. 8-bit maximum is 2 hits (0xB6).
- Reset mid-transaction: async return to IDLE with all outputs at their reset values. The partially sent byte is dropped with no done pulse. rr_ptr returns to 0.
- Glitch-free outputs: det_valid, det_din, det_clr and done are decoded from registered state and registers only. gnt is the only combinational output (from state, req and rr_ptr).

Test Plan:
1. req[0]=1, data0=0xB0 -> gnt[0] one cycle; det_din sequence 1,0,1,1,0,0,0,0; done 11 cycles after gnt; done_id=0, hit_cnt=1.
2. req[2]=1, data2=0xB6 -> hit_cnt=2 (overlapping matches at bits 3 and 6); data=0x00 -> hit_cnt=0; data=0xFF -> hit_cnt=0.
3. req=4'b1111 held with re-requests -> grant order 0,1,2,3,0; exactly one gnt bit high per IDLE cycle; 12-cycle spacing between done pulses.
4. det_hit forced to 1 during CLR and IDLE, with a correct detector otherwise, data=0x00 -> hit_cnt=0 (samples outside samp ignored).
5. Assert rst during SHIFT bit 4 -> all outputs 0 immediately; no done pulse; rr_ptr=0; the next req[1] alone is granted normally with the correct count.
6. Back-to-back bytes 0x0B then 0xB0 from the same requester -> det_clr pulse before each byte; hit_cnt=1 each time; no spurious hit from the trailing 1011 of 0x0B.
